axi_bcast_nx: RTL
=================

Name: axi_bcast_nx

Overview:
Parametrised AXI-Stream broadcaster. It fans one input stream out to N_OUT output streams, with full tvalid/tready handshaking on every port. Each output has its own first-word-fall-through FIFO, so a stalled consumer does not stall the others until its FIFO fills. It sits in the SDR datapath wherever one sample stream feeds several consumers, for example a demodulator, a monitor/ILA tap and a DMA path.

Parameters:
WIDTH, 16, tdata width in bits
N_OUT, 2, number of output channels (1..8)
DEPTH, 4, per-channel FIFO depth in beats; power of two, >= 2
DROP_ON_FULL, 0, 0 = backpressure mode; 1 = drop mode (full channels discard beats)
CNT_W, 16, width of each per-channel drop counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
I_tdata  input  WIDTH  input sample
I_tvalid  input  1  input valid
I_tready  output  1  input ready
ch_en  input  N_OUT  per-channel enable; bit k gates channel k
O_tdata  output  N_OUT*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
O_tvalid  output  N_OUT  per-channel valid
O_tready  input  N_OUT  per-channel ready
drop_cnt  output  N_OUT*CNT_W  channel k drop count at bits [k*CNT_W +: CNT_W]

Behaviour:
- Reset is synchronous to clk and active-low: on a clk edge with rst_n = 0, the following hold from the next cycle:
  - every FIFO is empty (count 0, pointers 0);
  - O_tvalid = 0 and I_tready = 0;
  - drop_cnt = 0; O_tdata don't-care.
- Reset mid-operation discards all buffered beats. No beat emitted after reset predates reset.
- Input handshake: accept = I_tvalid & I_tready.
- Backpressure mode (DROP_ON_FULL=0):
  - I_tready = rst_n & AND over k of (~ch_en[k] | ~full[k]).
  - full[k] is the registered count == DEPTH.
  - No combinational path from O_tready to I_tready.
  - A full channel blocks input even if it pops the same cycle.
- Drop mode (DROP_ON_FULL=1):
  - I_tready = rst_n.
  - On accept, each enabled full channel discards the beat and increments drop_cnt[k].
  - drop_cnt saturates at 2^CNT_W-1; it never wraps.
- Push: on accept, every channel with ch_en[k]=1 that is not dropping writes I_tdata.
  - Disabled channels receive nothing and never block.
- ch_en is sampled in the same cycle as the accept.
  - A channel disabled mid-stream keeps draining its buffered beats normally.
- Output: O_tvalid[k] = count[k] != 0; O_tdata[k] = FIFO head (FWFT, from registered storage).
  - Pop on O_tvalid[k] & O_tready[k].
  - O_tdata/O_tvalid hold stable while O_tvalid=1 and O_tready=0 (AXI rule).
- Latency: a beat accepted at edge t is visible on O at cycle t+1, provided the channel was empty.
  - Throughput is 1 beat/cycle per channel when O_tready is held high.
- Simultaneous push and pop on one channel: count unchanged, both pointers advance.
  - Legal at full in drop mode only if not dropping; a full channel drops regardless of the same-cycle pop.
- Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count is clog2(DEPTH)+1 bits.
- Ordering: each channel emits exactly the accepted, non-dropped beats in input order. No duplication.

Decomposition:
- Shared package/header: localparam AW = clog2(DEPTH); a clog2 function; slice-index macros for the flattened buses.
- One sub-module, axis_fifo_fwft (params WIDTH, DEPTH), instantiated N_OUT times via generate:
  - ports: clk, rst_n, push, din, full, pop, dout, empty.
- Top level holds the I_tready logic, per-channel push/drop decode and drop counters.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with I_tvalid=1 -> I_tready=0, O_tvalid=0, drop_cnt=0. After release, I_tready=1 next cycle.
- Streaming: N_OUT=2, all O_tready=1, send 0x0001..0x0010 back-to-back -> both channels output 0x0001..0x0010 in order, one per cycle, 1-cycle latency, no gaps.
- Backpressure: DEPTH=4, hold O_tready[1]=0, send 6 beats:
  - I_tready drops after the 4th accept; channel 0 drains 4 beats.
  - Release O_tready[1] -> beats 5,6 are accepted; both channels receive all 6.
- Drop mode: DROP_ON_FULL=1, O_tready[1]=0, send 10 beats -> channel 0 gets 10, channel 1 holds beats 1..4, drop_cnt[1]=6, drop_cnt[0]=0.
- Channel enable: clear ch_en[1] with 2 beats buffered, send 5 more -> channel 1 emits only the 2 old beats; I_tready never blocked by channel 1.
- Saturation/reset mid-stream: CNT_W=3, drop 10 beats -> drop_cnt=7. Then pulse rst_n=0 with FIFOs non-empty -> counters 0, O_tvalid=0, no stale beat afterwards.

Source files
------------

// File: rtl/axi_bcast_nx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_bcast_nx_pkg
// Description : Shared definitions for the AXI-Stream broadcaster.
//               Provides the operating-mode enum, a constant clog2 helper and
//               a slice macro for the flattened per-channel buses.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef AXI_BCAST_NX_PKG_MACROS
`define AXI_BCAST_NX_PKG_MACROS
// Selects lane k of a flattened bus whose lanes are w bits wide.
`define AXI_BCAST_SLICE(k, w) ((k)*(w)) +: (w)
`endif

package axi_bcast_nx_pkg;

  // Behaviour of a channel whose FIFO is full when the input offers a beat.
  typedef enum logic {
    MODE_BACKPRESSURE = 1'b0,
    MODE_DROP         = 1'b1
  } bcast_mode_e;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : axis_fifo_fwft
// Description : First-word-fall-through FIFO. The head entry is presented on
//               dout straight from registered storage whenever not empty.
// Ports       : clk, rst_n (sync, active-low)
//               push/din  - write din when push=1 (ignored while full)
//               pop       - retire the head entry (ignored while empty)
//               dout      - head entry, valid when empty=0
//               full      - registered count == DEPTH
//               empty     - registered count == 0
// Revision    : 1.0 - initial release
// ============================================================================
module axis_fifo_fwft
  import axi_bcast_nx_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      // DEPTH is a power of two, so pointers wrap naturally.
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: it is only observed through count/pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_bcast_nx.sv
`default_nettype none
// ============================================================================
// Module      : axi_bcast_nx
// Description : AXI-Stream broadcaster, one input fanned out to N_OUT outputs,
//               each behind its own FWFT FIFO. Full channels either stall the
//               input (DROP_ON_FULL=0) or discard and count beats (=1).
// Ports       : clk, rst_n (sync, active-low)
//               I_tdata/I_tvalid/I_tready - input stream
//               ch_en     - per-channel enable, sampled with the accept
//               O_tdata   - channel k at [k*WIDTH +: WIDTH]
//               O_tvalid/O_tready - per-channel handshake
//               drop_cnt  - channel k saturating drop count at [k*CNT_W +: CNT_W]
// Revision    : 1.0 - initial release
// ============================================================================
module axi_bcast_nx
  import axi_bcast_nx_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int N_OUT        = 2,
  parameter int DEPTH        = 4,
  parameter int DROP_ON_FULL = 0,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       I_tdata,
  input  logic                   I_tvalid,
  output logic                   I_tready,
  input  logic [N_OUT-1:0]       ch_en,
  output logic [N_OUT*WIDTH-1:0] O_tdata,
  output logic [N_OUT-1:0]       O_tvalid,
  input  logic [N_OUT-1:0]       O_tready,
  output logic [N_OUT*CNT_W-1:0] drop_cnt
);

  localparam bcast_mode_e MODE = (DROP_ON_FULL != 0) ? MODE_DROP : MODE_BACKPRESSURE;

  logic [N_OUT-1:0] full;
  logic [N_OUT-1:0] empty;
  logic [N_OUT-1:0] push;
  logic [N_OUT-1:0] drop;
  logic [N_OUT-1:0] pop;
  logic             tready;
  logic             accept;

  // Ready only looks at registered FIFO state, never at O_tready, so a full
  // channel blocks the input even when it is popping this cycle.
  always_comb begin
    tready = rst_n;
    if (MODE == MODE_BACKPRESSURE) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (ch_en[k] && full[k]) begin
          tready = 1'b0;
        end
      end
    end
  end

  assign I_tready = tready;
  assign accept   = I_tvalid & tready;
  assign O_tvalid = ~empty;
  assign pop      = O_tvalid & O_tready;

  always_comb begin
    push = '0;
    drop = '0;
    for (int k = 0; k < N_OUT; k++) begin
      push[k] = accept & ch_en[k] & ~full[k];
      drop[k] = (MODE == MODE_DROP) & accept & ch_en[k] & full[k];
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_ch
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    axis_fifo_fwft #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[k]),
      .din   (I_tdata),
      .full  (full[k]),
      .pop   (pop[k]),
      .dout  (O_tdata[`AXI_BCAST_SLICE(k, WIDTH)]),
      .empty (empty[k])
    );

    // Saturate at all-ones rather than wrapping.
    always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop[k] && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        drop_cnt_q <= '0;
      end else begin
        drop_cnt_q <= drop_cnt_d;
      end
    end

    assign drop_cnt[`AXI_BCAST_SLICE(k, CNT_W)] = drop_cnt_q;
  end

endmodule

`default_nettype wire
